// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an external N-bit universal shift register: load, shift, respond.
// Optional rotate mode is compiled in with `define SHIFT_SEQ_ROTATE_EN (adds port cmd_rot).
module shift_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_data,
    input  logic          cmd_dir,
    input  logic [CW-1:0] cmd_cnt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic          cmd_rot,
`endif
    input  logic          sin,
    output logic          sin_req,
    output logic          sout,
    output logic          sout_valid,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic [1:0]    sr_ctrl,
    output logic [N-1:0]  sr_d,
    input  logic [N-1:0]  sr_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_LEFT  = 2'b01;
    localparam logic [1:0] CTRL_RIGHT = 2'b10;
    localparam logic [1:0] CTRL_LOAD  = 2'b11;

    state_t        state_q,      state_d;
    logic          dir_q,        dir_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          cmd_ready_q,  cmd_ready_d;
    logic          sin_req_q,    sin_req_d;
    logic          sout_valid_q, sout_valid_d;
    logic          rsp_valid_q,  rsp_valid_d;
    logic [1:0]    sr_ctrl_q,    sr_ctrl_d;
    logic [N-1:0]  sr_d_q,       sr_d_d;
    logic          fill_s;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic          rot_q,        rot_d;
`endif

    // Counts larger than the register width are clamped when latched.
    function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] cnt);
        if (cnt > CW'(N)) begin
            return CW'(N);
        end else begin
            return cnt;
        end
    endfunction

    // Fill bit entering the register: serial input, or the outgoing bit when rotating.
    always_comb begin
        fill_s = sin;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rot_q) begin
            fill_s = dir_q ? sr_q[0] : sr_q[N-1];
        end else begin
            fill_s = sin;
        end
`endif
    end

    // Next-state and next-output decode for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        cmd_ready_d  = cmd_ready_q;
        sin_req_d    = sin_req_q;
        sout_valid_d = sout_valid_q;
        rsp_valid_d  = rsp_valid_q;
        sr_ctrl_d    = sr_ctrl_q;
        sr_d_d       = sr_d_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d        = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d     = ST_LOAD;
                    dir_d       = cmd_dir;
                    cnt_d       = sat_cnt(cmd_cnt);
                    cmd_ready_d = 1'b0;
                    sr_ctrl_d   = CTRL_LOAD;
                    sr_d_d      = cmd_data;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d       = cmd_rot;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sr_d_d = {N{1'b0}};
                if (cnt_q != {CW{1'b0}}) begin
                    state_d      = ST_SHIFT;
                    sr_ctrl_d    = dir_q ? CTRL_RIGHT : CTRL_LEFT;
                    sout_valid_d = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
                    sin_req_d    = ~rot_q;
`else
                    sin_req_d    = 1'b1;
`endif
                end else begin
                    state_d     = ST_DONE;
                    sr_ctrl_d   = CTRL_HOLD;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = ST_DONE;
                    sr_ctrl_d    = CTRL_HOLD;
                    sin_req_d    = 1'b0;
                    sout_valid_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cmd_ready_d  = 1'b1;
                sin_req_d    = 1'b0;
                sout_valid_d = 1'b0;
                rsp_valid_d  = 1'b0;
                sr_ctrl_d    = CTRL_HOLD;
                sr_d_d       = {N{1'b0}};
            end
        endcase
    end

    // State and registered-output flops; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            cnt_q        <= {CW{1'b0}};
            cmd_ready_q  <= 1'b1;
            sin_req_q    <= 1'b0;
            sout_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            sr_ctrl_q    <= CTRL_HOLD;
            sr_d_q       <= {N{1'b0}};
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            sin_req_q    <= sin_req_d;
            sout_valid_q <= sout_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            sr_ctrl_q    <= sr_ctrl_d;
            sr_d_q       <= sr_d_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q        <= rot_d;
`endif
        end
    end

    // Serial out and register data: only the shift-phase fill is combinational.
    always_comb begin
        if (sout_valid_q) begin
            sout = dir_q ? sr_q[0] : sr_q[N-1];
        end else begin
            sout = 1'b0;
        end
        if (state_q == ST_SHIFT) begin
            sr_d = {N{fill_s}};
        end else begin
            sr_d = sr_d_q;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign sin_req    = sin_req_q;
    assign sout_valid = sout_valid_q;
    assign rsp_valid  = rsp_valid_q;
    assign sr_ctrl    = sr_ctrl_q;
    assign rsp_data   = sr_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: models the universal shift register and scoreboards sout/rsp_data.
module tb_shift_seq_ctrl;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data;
    logic          cmd_dir;
    logic [CW-1:0] cmd_cnt;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic          cmd_rot;
`endif
    logic          sin;
    logic          sin_req;
    logic          sout;
    logic          sout_valid;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic [1:0]    sr_ctrl;
    logic [N-1:0]  sr_d;
    logic [N-1:0]  sr_q_s;

    int pass_cnt;
    int total_cnt;

    logic         sout_exp_q[$];
    logic [N-1:0] rsp_exp_q[$];

    shift_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_dir    (cmd_dir),
        .cmd_cnt    (cmd_cnt),
`ifdef SHIFT_SEQ_ROTATE_EN
        .cmd_rot    (cmd_rot),
`endif
        .sin        (sin),
        .sin_req    (sin_req),
        .sout       (sout),
        .sout_valid (sout_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .sr_ctrl    (sr_ctrl),
        .sr_d       (sr_d),
        .sr_q       (sr_q_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural universal shift register driven by the DUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q_s <= '0;
        end else begin
            case (sr_ctrl)
                2'b01:   sr_q_s <= {sr_q_s[N-2:0], sr_d[0]};
                2'b10:   sr_q_s <= {sr_d[N-1], sr_q_s[N-1:1]};
                2'b11:   sr_q_s <= sr_d;
                default: sr_q_s <= sr_q_s;
            endcase
        end
    end

    task automatic model_push(input logic [N-1:0] data, input logic dir, input int c,
                              input logic sinv, input logic rot);
        logic [N-1:0] w;
        logic o;
        logic f;
        w = data;
        for (int i = 0; i < c; i++) begin
            o = dir ? w[0] : w[N-1];
            sout_exp_q.push_back(o);
            f = rot ? o : sinv;
            w = dir ? {f, w[N-1:1]} : {w[N-2:0], f};
        end
        rsp_exp_q.push_back(w);
    endtask

    task automatic exec_cmd(input string name, input logic [N-1:0] data, input logic dir,
                            input int cnt, input logic sinv, input logic rot, input int hold);
        int csat;
        int sinreq_seen;
        bit got;
        logic exp_b;
        logic [N-1:0] exp_d;
        csat = (cnt > N) ? N : cnt;
        exp_d = '0;
        @(posedge clk); #1;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready before: got %b want 1", name, cmd_ready);
        else pass_cnt++;
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_cnt   = CW'(cnt);
        sin       = sinv;
        rsp_ready = (hold == 0);
`ifdef SHIFT_SEQ_ROTATE_EN
        cmd_rot   = rot;
`endif
        model_push(data, dir, csat, sinv, rot);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = 1'b0;
        sinreq_seen = 0;
        for (int c = 1; c <= N + 6 && !got; c++) begin
            @(negedge clk);
            if (sin_req === 1'b1) sinreq_seen++;
            if (sout_valid === 1'b1) begin
                total_cnt++;
                if (sout_exp_q.size() == 0) begin
                    $display("FAIL %s extra sout cycle %0d: got sout_valid 1 want 0", name, c);
                end else begin
                    exp_b = sout_exp_q.pop_front();
                    if (sout !== exp_b) $display("FAIL %s sout cycle %0d: got %b want %b", name, c, sout, exp_b);
                    else pass_cnt++;
                end
            end
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                total_cnt++;
                if (c != csat + 2) $display("FAIL %s latency: got %0d want %0d", name, c, csat + 2);
                else pass_cnt++;
                exp_d = rsp_exp_q.pop_front();
                total_cnt++;
                if (rsp_data !== exp_d) $display("FAIL %s rsp_data: got %h want %h", name, rsp_data, exp_d);
                else pass_cnt++;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL %s timeout: got no rsp_valid want rsp_valid in cycle %0d", name, csat + 2);
            rsp_exp_q.delete();
        end
        total_cnt++;
        if (sinreq_seen != (rot ? 0 : csat))
            $display("FAIL %s sin_req cycles: got %0d want %0d", name, sinreq_seen, rot ? 0 : csat);
        else pass_cnt++;
        total_cnt++;
        if (sout_exp_q.size() != 0) $display("FAIL %s sout count: got %0d missing want 0", name, sout_exp_q.size());
        else pass_cnt++;
        sout_exp_q.delete();
        if (got) begin
            if (hold > 0) begin
                cmd_valid = 1'b1;
                cmd_data  = ~data;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    total_cnt++;
                    if (rsp_valid !== 1'b1 || rsp_data !== exp_d || cmd_ready !== 1'b0)
                        $display("FAIL %s hold %0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                                 name, h, rsp_valid, rsp_data, cmd_ready, exp_d);
                    else pass_cnt++;
                end
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            @(negedge clk);
            total_cnt++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || sr_ctrl !== 2'b00)
                $display("FAIL %s after handshake: got rdy=%b v=%b ctrl=%b want rdy=1 v=0 ctrl=00",
                         name, cmd_ready, rsp_valid, sr_ctrl);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); else pass_cnt++;
        total_cnt++;
        if (sin_req !== 1'b0 || sout !== 1'b0 || sout_valid !== 1'b0)
            $display("FAIL reset serial: got req=%b sout=%b sv=%b want 0 0 0", sin_req, sout, sout_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0)
            $display("FAIL reset rsp: got v=%b d=%h want 0 00", rsp_valid, rsp_data);
        else pass_cnt++;
        total_cnt++;
        if (sr_ctrl !== 2'b00 || sr_d !== '0)
            $display("FAIL reset sr: got ctrl=%b d=%h want 00 00", sr_ctrl, sr_d);
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        exec_cmd("left3",  8'hA5, 1'b0, 3,  1'b1, 1'b0, 0);
        exec_cmd("right2", 8'hA5, 1'b1, 2,  1'b0, 1'b0, 0);
        exec_cmd("cnt0",   8'h3C, 1'b0, 0,  1'b1, 1'b0, 0);
        exec_cmd("sat12",  8'hC3, 1'b0, 12, 1'b0, 1'b0, 0);
        exec_cmd("sat9r",  8'h5A, 1'b1, 9,  1'b1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        exec_cmd("hold5", 8'h96, 1'b1, 3, 1'b1, 1'b0, 5);
    endtask

    task automatic test_reset_mid_shift();
        int rsp_seen;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = 8'hF0;
        cmd_dir   = 1'b0;
        cmd_cnt   = CW'(8);
        sin       = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sout_valid !== 1'b1) $display("FAIL midreset in shift: got sout_valid %b want 1", sout_valid);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (cmd_ready !== 1'b1 || sin_req !== 1'b0 || sout !== 1'b0 || sout_valid !== 1'b0 ||
            rsp_valid !== 1'b0 || sr_ctrl !== 2'b00 || sr_d !== '0)
            $display("FAIL midreset outputs: got rdy=%b req=%b sout=%b sv=%b v=%b ctrl=%b d=%h want 1 0 0 0 0 00 00",
                     cmd_ready, sin_req, sout, sout_valid, rsp_valid, sr_ctrl, sr_d);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        total_cnt++;
        if (rsp_seen != 0 || cmd_ready !== 1'b1)
            $display("FAIL midreset aftermath: got rsp cycles %0d rdy=%b want 0 and 1", rsp_seen, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = 8'h5A;
        cmd_dir   = 1'b1;
        cmd_cnt   = CW'(1);
        sin       = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) acc.push_back(cyc);
            if (rsp_valid === 1'b1) begin
                total_cnt++;
                if (rsp_data !== 8'hAD) $display("FAIL b2b rsp_data: got %h want ad", rsp_data);
                else pass_cnt++;
            end
        end
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (acc.size() < 4) $display("FAIL b2b accepts: got %0d want >= 4", acc.size());
        else pass_cnt++;
        for (int i = 0; i + 1 < acc.size(); i++) begin
            total_cnt++;
            if (acc[i+1] - acc[i] != 4) $display("FAIL b2b spacing %0d: got %0d want 4", i, acc[i+1] - acc[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            exec_cmd("rand", N'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                     1'($urandom_range(0, 1)), 1'b0, 0);
        end
    endtask

`ifdef SHIFT_SEQ_ROTATE_EN
    task automatic test_rotate();
        exec_cmd("rot81", 8'h81, 1'b0, 1, 1'b0, 1'b1, 0);
        exec_cmd("rotr3", 8'h0D, 1'b1, 3, 1'b0, 1'b1, 0);
        cmd_rot = 1'b0;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_cnt   = '0;
        sin       = 1'b0;
        rsp_ready = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
        cmd_rot   = 1'b0;
`endif
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
`ifdef SHIFT_SEQ_ROTATE_EN
        test_rotate();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
